// File: rtl/booth_r8_seq_mult.sv
// rtl/booth_r8_seq_mult.sv - iterative radix-8 Booth signed multiplier with valid/ready handshakes
module booth_r8_seq_mult #(
    parameter int A_W = 8,
    parameter int B_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a_in,
    input  logic [B_W-1:0]       b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   p_out,
    output logic                 busy
);
    localparam int N     = (B_W + 2) / 3;
    localparam int BX    = 3 * N;
    localparam int ACC_W = A_W + BX + 3;
    localparam int PP_W  = A_W + 3;
    localparam int P_W   = A_W + B_W;
    localparam int IDX_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, PRECOMP, ITER, DONE} state_t;

    state_t                   state, state_nxt;
    logic signed [A_W-1:0]    a_reg;
    logic        [BX:0]       b_reg;
    logic signed [A_W+1:0]    a3;
    logic signed [ACC_W-1:0]  acc;
    logic        [IDX_W-1:0]  idx;
    logic        [3:0]        code;
    logic signed [PP_W-1:0]   mag;
    logic signed [PP_W-1:0]   pp;
    logic signed [ACC_W-1:0]  pp_sh;
    logic signed [BX-1:0]     b_sx;
    logic                     last_digit;

    assign last_digit = (idx == IDX_W'(N - 1));
    assign b_sx       = BX'($signed(b_in));
    assign p_out      = acc[P_W-1:0];

    // b_reg shifts right by 3 each digit, so the current window always sits in bits [3:0]
    always_comb begin
        code = 4'b0000;
        case (b_reg[3:0])
            4'b0000, 4'b1111: code = 4'b0000;
            4'b0001, 4'b0010: code = 4'b0001;
            4'b0011, 4'b0100: code = 4'b0010;
            4'b0101, 4'b0110: code = 4'b0011;
            4'b0111:          code = 4'b0100;
            4'b1000:          code = 4'b1100;
            4'b1001, 4'b1010: code = 4'b1011;
            4'b1011, 4'b1100: code = 4'b1010;
            4'b1101, 4'b1110: code = 4'b1001;
            default:          code = 4'b0000;
        endcase
    end

    always_comb begin
        mag = '0;
        case (code[2:0])
            3'd1:    mag = {{3{a_reg[A_W-1]}}, a_reg};
            3'd2:    mag = {{2{a_reg[A_W-1]}}, a_reg, 1'b0};
            3'd3:    mag = {a3[A_W+1], a3};
            3'd4:    mag = {a_reg[A_W-1], a_reg, 2'b00};
            default: mag = '0;
        endcase
        pp    = code[3] ? -mag : mag;
        pp_sh = ACC_W'(pp) <<< (3 * idx);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = PRECOMP;
            end
            PRECOMP: state_nxt = ITER;
            ITER:    if (last_digit) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            a3    <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a_in;
                        b_reg <= {b_sx, 1'b0};
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                PRECOMP: a3 <= ((A_W+2)'(a_reg) <<< 1) + (A_W+2)'(a_reg);
                ITER: begin
                    acc   <= acc + pp_sh;
                    b_reg <= b_reg >> 3;
                    idx   <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// tb/tb_booth_r8_seq_mult.sv - directed, random and small exhaustive checks of booth_r8_seq_mult
module tb_booth_r8_seq_mult;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid, in_ready, out_valid, out_ready, busy;
    logic signed [7:0]  a_in;
    logic signed [8:0]  b_in;
    logic signed [16:0] p_out;

    logic               in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    logic signed [3:0]  a_s;
    logic signed [5:0]  b_s;
    logic signed [9:0]  p_s;

    int checks = 0;
    int errors = 0;

    booth_r8_seq_mult dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .p_out(p_out), .busy(busy)
    );

    booth_r8_seq_mult #(.A_W(4), .B_W(6)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .a_in(a_s), .b_in(b_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .p_out(p_s), .busy(busy_s)
    );

    int va [12] = '{5, -128, 127, -128, 100, 0, -1, 127, -128, 37, -99, -1};
    int vb [12] = '{3, -256, 255, 255, -220, -1, -1, -256, -1, -45, 173, 255};
    int vp [12] = '{15, 32768, 32385, -32640, -22000, 0, 1, -32512, 128, -1665, -17127, -255};

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input int a, input int b);
        a_in     = 8'(a);
        b_in     = 9'(b);
        in_valid = 1'b1;
        check("accept_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bsy);
        lat = 0;
        bsy = busy ? 1 : 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bsy++;
        end
    endtask

    task automatic run(input string tag, input int a, input int b, input longint exp);
        int lat, bsy;
        out_ready = 1'b1;
        accept(a, b);
        wait_done(lat, bsy);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_p"}, longint'(p_out), exp);
        @(posedge clk); #1;
        check({tag, "_ov_drop"}, longint'(out_valid), 0);
    endtask

    initial begin
        int lat, bsy;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
        in_valid_s = 1'b0; out_ready_s = 1'b1; a_s = '0; b_s = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_p", longint'(p_out), 0);

        // first vector also checks busy duration
        accept(5, 3);
        wait_done(lat, bsy);
        check("v0_lat", lat, 4);
        check("v0_p", longint'(p_out), 15);
        @(posedge clk); #1;
        if (busy) bsy++;
        check("v0_busy_cycles", bsy, 5);
        check("v0_idle_busy", longint'(busy), 0);

        for (int i = 1; i < 12; i++) run($sformatf("vec%0d", i), va[i], vb[i], vp[i]);

        // backpressure: product held while new operands are offered
        out_ready = 1'b0;
        accept(12, -11);
        wait_done(lat, bsy);
        check("bp_lat", lat, 4);
        check("bp_p", longint'(p_out), -132);
        for (int k = 0; k < 6; k++) begin
            in_valid = k[0];
            a_in = 8'(k * 9 + 1);
            b_in = 9'(-k * 17 - 3);
            @(posedge clk); #1;
            check("bp_hold_ov", longint'(out_valid), 1);
            check("bp_hold_p", longint'(p_out), -132);
            check("bp_hold_ready", longint'(in_ready), 0);
        end
        a_in = 8'(3); b_in = 9'(4); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", longint'(out_valid), 0);
        check("bp_release_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(lat, bsy);
        check("bp_next_lat", lat, 4);
        check("bp_next_p", longint'(p_out), 12);
        @(posedge clk); #1;

        // reset during ITER digit 1
        accept(-50, 7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ov", longint'(out_valid), 0);
        check("midrst_ready", longint'(in_ready), 1);
        check("midrst_p", longint'(p_out), 0);
        check("midrst_busy", longint'(busy), 0);
        run("after_rst", -7, 9, -63);

        for (int r = 0; r < 2000; r++) begin
            int ra, rb;
            ra = $signed(8'($urandom));
            rb = $signed(9'($urandom));
            run("rand", ra, rb, longint'(ra) * longint'(rb));
        end

        for (int ia = -8; ia < 8; ia++) begin
            for (int ib = -32; ib < 32; ib++) begin
                int sl;
                a_s = 4'(ia); b_s = 6'(ib); in_valid_s = 1'b1;
                @(posedge clk); #1;
                in_valid_s = 1'b0;
                sl = 0;
                while (!out_valid_s && sl < 20) begin
                    @(posedge clk); #1;
                    sl++;
                end
                check("small_lat", sl, 3);
                check("small_p", longint'(p_s), longint'(ia * ib));
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
